ram_bus_master: RTL and testbench

RAM_BUS_MASTER -- requirements
Module: ram_bus_master

---
 rtl/ram_bus_master.sv | 115 +++++++++++
 tb/tb_ram_bus_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_master.sv
// ============================================================================
// Module   : ram_bus_master
// Summary  : Single-request master that turns req/rsp handshakes into
//            MAR/MDR/CS/MDR_bus strobe sequences on a shared tri-state bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_bus_master #(
  parameter  int WORD_W = 8,
  parameter  int OP_W   = 3,
  localparam int AW     = WORD_W - OP_W
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rnw,
  input  logic [AW-1:0]     req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              load_MAR,
  output logic              load_MDR,
  output logic              CS,
  output logic              MDR_bus,
  output logic              R_NW,
  inout  wire  [WORD_W-1:0] sysbus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WDATA  = 3'd2,
    S_ACCESS = 3'd3,
    S_RDATA  = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_rnw;
  logic [AW-1:0]       r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic                r_drive;
  logic                w_addr_ok;
  logic [WORD_W-1:0]   w_bus_out;

  // Only the upper half of the address space is mapped, minus the top two words.
  assign w_addr_ok = req_addr[AW-1] && (int'(req_addr) < 30);

  assign w_bus_out = load_MAR ? WORD_W'(r_addr) : r_wdata;
  assign sysbus    = r_drive ? w_bus_out : {WORD_W{1'bz}};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next = w_addr_ok ? S_ADDR : S_RESP;
      S_ADDR:   w_next = r_rnw ? S_ACCESS : S_WDATA;
      S_WDATA:  w_next = S_ACCESS;
      S_ACCESS: w_next = r_rnw ? S_RDATA : S_RESP;
      S_RDATA:  w_next = S_RESP;
      S_RESP:   if (rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Every output is registered from the next state so it lines up with r_state.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state   <= S_IDLE;
      r_rnw     <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_drive   <= 1'b0;
      req_ready <= 1'b1;
      load_MAR  <= 1'b0;
      load_MDR  <= 1'b0;
      CS        <= 1'b0;
      MDR_bus   <= 1'b0;
      R_NW      <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && req_valid) begin
        r_rnw   <= req_rnw;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      req_ready <= (w_next == S_IDLE);
      load_MAR  <= (w_next == S_ADDR);
      load_MDR  <= (w_next == S_WDATA);
      CS        <= (w_next == S_ACCESS);
      MDR_bus   <= (w_next == S_RDATA);
      R_NW      <= (w_next == S_ACCESS) ? r_rnw : 1'b1;
      r_drive   <= (w_next == S_ADDR) || (w_next == S_WDATA);
      rsp_valid <= (w_next == S_RESP);
      if (w_next != S_RESP)
        rsp_err <= 1'b0;
      else if (r_state == S_IDLE)
        rsp_err <= 1'b1;
      else if (r_state != S_RESP)
        rsp_err <= 1'b0;
      if (r_state == S_RDATA)
        rsp_rdata <= sysbus;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_bus_master.sv
// ============================================================================
// Module   : tb_ram_bus_master
// Summary  : Self-checking bench for ram_bus_master with an attached RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_bus_master;

  logic       clock = 1'b0;
  logic       n_reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rnw = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_ready = 1'b0;
  logic       req_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       load_MAR, load_MDR, CS, MDR_bus, R_NW;
  wire  [7:0] sysbus;

  int n_checks = 0;
  int n_errors = 0;

  ram_bus_master #(.WORD_W(8), .OP_W(3)) dut (
    .clock(clock), .n_reset(n_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .load_MAR(load_MAR), .load_MDR(load_MDR), .CS(CS),
    .MDR_bus(MDR_bus), .R_NW(R_NW), .sysbus(sysbus)
  );

  always #5 clock = ~clock;

  // Simple MAR/MDR RAM hanging off the shared bus
  logic [7:0] ram_mem [0:31] = '{default: 8'h00};
  logic [4:0] ram_mar = '0;
  logic [7:0] ram_mdr = '0;
  assign sysbus = MDR_bus ? ram_mdr : 8'hzz;
  always @(posedge clock) begin
    if (load_MAR) ram_mar <= sysbus[4:0];
    if (load_MDR) ram_mdr <= sysbus;
    if (CS && !R_NW) ram_mem[ram_mar] <= ram_mdr;
    if (CS && R_NW) ram_mdr <= ram_mem[ram_mar];
  end

  // Reference: memory contents and last read value, by the request rules alone
  logic [7:0] ref_mem [0:31];
  logic [7:0] ref_rdata;

  function automatic bit addr_valid(input logic [4:0] a);
    return (a >= 5'd16) && (a <= 5'd29);
  endfunction

  task automatic model_update(input bit rnw, input logic [4:0] a, input logic [7:0] d);
    if (addr_valid(a)) begin
      if (rnw) ref_rdata = ref_mem[a];
      else     ref_mem[a] = d;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "/strobes"}, {load_MAR, load_MDR, CS, MDR_bus}, 0);
    chk({tag, "/R_NW"}, R_NW, 1);
    chk({tag, "/rsp_valid"}, rsp_valid, 0);
    chk({tag, "/rsp_err"}, rsp_err, 0);
    chk({tag, "/rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "/req_ready"}, req_ready, 1);
  endtask

  // Bus rules checked on every falling edge out of reset
  initial forever begin
    @(negedge clock);
    if (n_reset === 1'b1) begin
      chk("bus/one_strobe", ($countones({load_MAR, load_MDR, CS, MDR_bus}) <= 1), 1);
      if (MDR_bus) chk("bus/no_contention", sysbus, ram_mdr);
      if (!CS) chk("bus/rnw_outside_access", R_NW, 1);
    end
  end

  task automatic run_txn(input string tag, input bit rnw, input logic [4:0] addr,
                         input logic [7:0] wdata, input int hold,
                         input bit exp_err, input logic [7:0] exp_rdata);
    int lat, n_mar, n_mdr, n_cs, n_mdrbus;
    logic [15:0] strobe_cnt;
    lat = 0; n_mar = 0; n_mdr = 0; n_cs = 0; n_mdrbus = 0;
    @(negedge clock);
    chk({tag, "/req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_rnw = rnw; req_addr = addr; req_wdata = wdata;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_rnw = 1'($urandom); req_addr = 5'($urandom); req_wdata = 8'($urandom);
    for (int n = 1; n <= 12; n++) begin
      if (rsp_valid) begin lat = n; break; end
      if (load_MAR) begin n_mar++; chk({tag, "/mar_bus"}, sysbus, {3'b000, addr}); end
      if (load_MDR) begin n_mdr++; chk({tag, "/mdr_bus"}, sysbus, wdata); end
      if (CS) begin n_cs++; chk({tag, "/cs_rnw"}, R_NW, rnw); end
      if (MDR_bus) n_mdrbus++;
      rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    rsp_ready = 1'b0;
    chk({tag, "/latency"}, lat, exp_err ? 1 : 4);
    strobe_cnt = {n_mar[3:0], n_mdr[3:0], n_cs[3:0], n_mdrbus[3:0]};
    chk({tag, "/strobe_counts"}, strobe_cnt, exp_err ? 16'h0000 : (rnw ? 16'h1011 : 16'h1110));
    chk({tag, "/rsp_err"}, rsp_err, exp_err);
    chk({tag, "/rsp_rdata"}, rsp_rdata, exp_rdata);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_rnw = 1'b0; req_addr = 5'h14; req_wdata = 8'h77;
      @(posedge clock); #1;
      chk({tag, "/hold_valid"}, rsp_valid, 1);
      chk({tag, "/hold_ready"}, req_ready, 0);
      chk({tag, "/hold_err"}, rsp_err, exp_err);
      chk({tag, "/hold_rdata"}, rsp_rdata, exp_rdata);
      chk({tag, "/hold_strobes"}, {load_MAR, load_MDR, CS, MDR_bus}, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    chk({tag, "/rsp_drop"}, rsp_valid, 0);
    chk({tag, "/back_idle"}, req_ready, 1);
  endtask

  typedef struct {
    bit         rnw;
    logic [4:0] addr;
    logic [7:0] wdata;
    int         hold;
    bit         exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl [14];

  initial begin
    bit         r_rnw;
    logic [4:0] r_addr;
    logic [7:0] r_wdata;
    bit         e_err;
    logic [7:0] e_rdata;

    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
    ref_rdata = 8'h00;

    tbl[0]  = '{1'b0, 5'h12, 8'hA5, 0,  1'b0, 8'h00};
    tbl[1]  = '{1'b1, 5'h12, 8'h00, 0,  1'b0, 8'hA5};
    tbl[2]  = '{1'b0, 5'h05, 8'h11, 0,  1'b1, 8'hA5};
    tbl[3]  = '{1'b0, 5'h1E, 8'h22, 0,  1'b1, 8'hA5};
    tbl[4]  = '{1'b1, 5'h05, 8'h00, 0,  1'b1, 8'hA5};
    tbl[5]  = '{1'b1, 5'h12, 8'h00, 0,  1'b0, 8'hA5};
    tbl[6]  = '{1'b0, 5'h1D, 8'h3C, 10, 1'b0, 8'hA5};
    tbl[7]  = '{1'b1, 5'h1D, 8'h00, 0,  1'b0, 8'h3C};
    tbl[8]  = '{1'b1, 5'h14, 8'h00, 0,  1'b0, 8'h00};
    tbl[9]  = '{1'b0, 5'h10, 8'hFF, 0,  1'b0, 8'h00};
    tbl[10] = '{1'b1, 5'h10, 8'h00, 0,  1'b0, 8'hFF};
    tbl[11] = '{1'b1, 5'h1F, 8'h00, 0,  1'b1, 8'hFF};
    tbl[12] = '{1'b0, 5'h0F, 8'h01, 0,  1'b1, 8'hFF};
    tbl[13] = '{1'b1, 5'h11, 8'h00, 3,  1'b0, 8'h00};

    #12;
    chk_reset_vals("reset");
    @(negedge clock); n_reset = 1'b1;
    @(posedge clock); #1;
    chk("reset_release/req_ready", req_ready, 1);

    for (int i = 0; i < 14; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].rnw, tbl[i].addr, tbl[i].wdata,
              tbl[i].hold, tbl[i].exp_err, tbl[i].exp_rdata);
      model_update(tbl[i].rnw, tbl[i].addr, tbl[i].wdata);
    end

    // Reset pulse while a write sits in its access cycle
    @(negedge clock);
    req_valid = 1'b1; req_rnw = 1'b0; req_addr = 5'h15; req_wdata = 8'h99;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("rst_mid/addr_phase", load_MAR, 1);
    @(posedge clock); #1;
    chk("rst_mid/wdata_phase", load_MDR, 1);
    @(posedge clock); #1;
    chk("rst_mid/access_phase", {CS, R_NW}, 2'b10);
    #2 n_reset = 1'b0;
    #1 chk_reset_vals("rst_mid/async");
    @(posedge clock); #1;
    chk("rst_mid/held_valid", rsp_valid, 0);
    @(negedge clock); n_reset = 1'b1;
    @(posedge clock); #1;
    chk("rst_mid/ready_after", req_ready, 1);
    chk("rst_mid/no_rsp", rsp_valid, 0);
    ref_rdata = 8'h00;
    run_txn("post_rst_w13", 1'b0, 5'h13, 8'h5A, 0, 1'b0, ref_rdata);
    model_update(1'b0, 5'h13, 8'h5A);
    run_txn("post_rst_r15", 1'b1, 5'h15, 8'h00, 0, 1'b0, ref_mem[5'h15]);
    model_update(1'b1, 5'h15, 8'h00);
    run_txn("post_rst_r13", 1'b1, 5'h13, 8'h00, 0, 1'b0, ref_mem[5'h13]);
    model_update(1'b1, 5'h13, 8'h00);

    // Randomized traffic, biased toward the mapped window
    for (int i = 0; i < 40; i++) begin
      r_rnw   = 1'($urandom_range(0, 1));
      r_addr  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                            : 5'($urandom_range(14, 31));
      r_wdata = 8'($urandom);
      e_err   = !addr_valid(r_addr);
      e_rdata = (!e_err && r_rnw) ? ref_mem[r_addr] : ref_rdata;
      run_txn($sformatf("rnd%0d", i), r_rnw, r_addr, r_wdata,
              $urandom_range(0, 2), e_err, e_rdata);
      model_update(r_rnw, r_addr, r_wdata);
    end

    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
